// File: rtl/vp_bbox_overlay.sv
// Bounding-box overlay stage after the vp LUT processor: accumulates the foreground box per frame
// and draws it over the next frame. Optional centre crosshair under the BBOX_CROSS_EN macro.
module vp_bbox_overlay #(
    parameter int          COORD_W   = 11,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_in,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [23:0] pixel_in,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [23:0] pixel_out
);

    logic [COORD_W-1:0] x, y, y_acc;
    logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
    logic [COORD_W-1:0] bx0, bx1, by0, by1;
    logic               de_prev, v_prev, found, box_valid;
    logic               fg, frame_start, on_edge, on_cross, on_box;

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic in_range(input logic [COORD_W-1:0] v, lo, hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign fg          = de_in & pixel_in[23];
    assign frame_start = v_sync_in & ~v_prev;
    // A pixel landing on the boundary cycle belongs to the new frame, whose first row is y=0.
    assign y_acc       = frame_start ? '0 : y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            de_prev <= 1'b0;
            v_prev  <= 1'b0;
        end else begin
            de_prev <= de_in;
            v_prev  <= v_sync_in;
            x       <= de_in ? sat_inc(x) : '0;
            if (frame_start)
                y <= '0;
            else if (de_prev && !de_in)
                y <= sat_inc(y);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_x     <= '1;
            min_y     <= '1;
            max_x     <= '0;
            max_y     <= '0;
            found     <= 1'b0;
            bx0       <= '0;
            bx1       <= '0;
            by0       <= '0;
            by1       <= '0;
            box_valid <= 1'b0;
        end else if (frame_start) begin
            bx0       <= min_x;
            bx1       <= max_x;
            by0       <= min_y;
            by1       <= max_y;
            box_valid <= found;
            min_x     <= fg ? x : '1;
            max_x     <= fg ? x : '0;
            min_y     <= fg ? y_acc : '1;
            max_y     <= fg ? y_acc : '0;
            found     <= fg;
        end else if (fg) begin
            if (x < min_x) min_x <= x;
            if (x > max_x) max_x <= x;
            if (y < min_y) min_y <= y;
            if (y > max_y) max_y <= y;
            found <= 1'b1;
        end
    end

`ifdef BBOX_CROSS_EN
    logic [COORD_W:0]   sum_x, sum_y;
    logic [COORD_W-1:0] cx, cy;

    assign sum_x = {1'b0, min_x} + {1'b0, max_x};
    assign sum_y = {1'b0, min_y} + {1'b0, max_y};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx <= '0;
            cy <= '0;
        end else if (frame_start) begin
            cx <= COORD_W'(sum_x >> 1);
            cy <= COORD_W'(sum_y >> 1);
        end
    end

    assign on_cross = ((x == cx) && in_range(y, by0, by1)) ||
                      ((y == cy) && in_range(x, bx0, bx1));
`else
    assign on_cross = 1'b0;
`endif

    assign on_edge = (((x == bx0) || (x == bx1)) && in_range(y, by0, by1)) ||
                     (((y == by0) || (y == by1)) && in_range(x, bx0, bx1));
    assign on_box  = box_valid & de_in & (on_edge | on_cross);

    // Output stage: single register, sync signals travel alongside the pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
            pixel_out  <= '0;
        end else begin
            de_out     <= de_in;
            h_sync_out <= h_sync_in;
            v_sync_out <= v_sync_in;
            pixel_out  <= on_box ? BOX_COLOR : pixel_in;
        end
    end

endmodule

// File: doc/vp_bbox_overlay.md
Name: vp_bbox_overlay

Overview:
- Processing stage directly downstream of the LUT vision processor (vp).
- Takes vp's binarised video stream, accumulates the bounding box of foreground pixels over each frame, and commits the box at the frame boundary.
- Draws the box as a 1-pixel rectangle over the following frame, then passes the stream on to the HDMI output.
- One pipeline register stage; sync signals delayed to match.

Parameters:
- COORD_W, 11: width of the x/y coordinate counters and box registers.
- BOX_COLOR, 24'hFF0000: RGB value drawn on box pixels.

Ports:
- clk, input, 1: pixel clock.
- rst, input, 1: asynchronous active-high reset.
- de_in, input, 1: data enable from vp.
- h_sync_in, input, 1: horizontal sync from vp.
- v_sync_in, input, 1: vertical sync from vp; high = sync.
- pixel_in, input, 24: {R,G,B} from vp.
- de_out, output, 1: de_in delayed 1 clk.
- h_sync_out, output, 1: h_sync_in delayed 1 clk.
- v_sync_out, output, 1: v_sync_in delayed 1 clk.
- pixel_out, output, 24: pixel_in delayed 1 clk, with box overlay applied.

Behaviour:
- Reset: all outputs 0; x=0, y=0; accumulators min_x=min_y=all-ones, max_x=max_y=0; found=0; box_valid=0. Reset mid-frame abandons the partial frame. The partial frame after reset is accumulated and commits at the first v_sync rising edge.
- Foreground: fg = de_in & pixel_in[23] (MSB of red; vp emits 0x00/0xFF per channel).
- x counter: increments on every de_in=1 cycle; cleared on any cycle with de_in=0; saturates at 2^COORD_W-1.
- y counter: increments on de falling edge (de_prev=1, de_in=0); saturates; cleared on frame boundary.
- Frame boundary: v_sync_in rising edge (registered v_prev=0, v_sync_in=1).
- Accumulate: on fg at (x,y):
  - min_x = min(min_x,x); max_x = max(max_x,x)
  - min_y = min(min_y,y); max_y = max(max_y,y)
  - found=1
- Commit at frame boundary:
  - box registers <= accumulators; box_valid <= found.
  - Accumulators and found return to reset values in the same cycle.
  - If a boundary and fg coincide, the commit takes priority and the fg pixel seeds the new frame's accumulators (min=max=that coordinate, found=1).
- Overlay, evaluated on the cycle's x,y, registered to the outputs:
  - on_box = box_valid & de_in & ((x==bx0 | x==bx1) & y in [by0,by1] | (y==by0 | y==by1) & x in [bx0,bx1]).
  - pixel_out <= on_box ? BOX_COLOR : pixel_in.
- Latency: exactly 1 clk for all outputs; no stalls; no handshake.
- Single-pixel object gives bx0=bx1, by0=by1: one pixel drawn.
- Empty frame: box_valid=0; next frame passes through unmodified.
- Box never moves mid-frame: only the commit updates it.

Optional Feature:
- Macro: BBOX_CROSS_EN.
- Defined:
  - Adds registered centre cx=(bx0+bx1)>>1 and cy=(by0+by1)>>1, computed at commit in COORD_W+1 bits, then truncated.
  - Pixels with x==cx and y in [by0,by1], or y==cy and x in [bx0,bx1], are also drawn in BOX_COLOR.
  - Latency unchanged.
- Undefined: rectangle only; cx/cy logic absent.

Test Plan:
- 64x64 frames, one fg pixel at (10,20) in frame 0 -> frame 1 pixel (10,20) = FF0000; all other pixels pass through; outputs lag inputs by exactly 1 clk.
- Frame 0 fg block x 5..14, y 3..8 -> frame 1: rows 3 and 8, x 5..14, red; cols 5 and 14, y 3..8, red; (9,5) unmodified.
- Frame 0 has box, frame 1 has no fg -> frame 2 passes through bit-exact (box_valid=0).
- rst pulsed for 3 clk mid-frame 1 after box committed -> outputs 0 during reset; rest of frame unmodified; commit at next vsync uses only post-reset pixels.
- fg asserted in the same cycle as the v_sync rising edge (forced) -> previous box committed; new frame min=max=(0,y reset value), found=1.
- BBOX_CROSS_EN defined, box x 4..12, y 2..10 -> column x=8 and row y=6 inside the box are red; without the macro those pixels are unmodified.
